// File: rtl/icap_cmd_seq.sv
// ICAP command sequencer: wraps one configuration register read or write in
// dummy/sync/header/NOOP framing and a trailing desync.
module icap_cmd_seq #(
    parameter int          DATA_W   = 16,
    parameter logic [5:0]  CMD_ADDR = 6'h05,
    parameter int          NOOP_CNT = 2,
    parameter int          BIT_SWAP = 1,
    parameter int          TIMEOUT  = 255
) (
    input  logic              CLK,
    input  logic              RST_B,
    input  logic              REQ,
    input  logic              REQ_RD,
    input  logic [5:0]        REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              ACK,
    output logic              ERR,
    output logic [DATA_W-1:0] RDATA,
    output logic              SEQ_BUSY,
    output logic              ICAP_CE,
    output logic              ICAP_WRITE,
    output logic [DATA_W-1:0] ICAP_I,
    input  logic [DATA_W-1:0] ICAP_O,
    input  logic              ICAP_BUSY
);

    typedef enum logic [3:0] {
        S_IDLE, S_DUMMY, S_SYNC, S_HDR, S_WDATA, S_NOOP, S_RD_TURN,
        S_RD_CAP, S_RD_BACK, S_RD_REST, S_DSH, S_DSD, S_DONE
    } state_t;

    localparam logic [15:0] NOOP_LAST = 16'(NOOP_CNT - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                rd_q, rd_d;
    logic [5:0]          addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                errflag_q, errflag_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ce_q, ce_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   icap_i_q, icap_i_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   word;

    function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < DATA_W / 8; b++) begin
            for (int unsigned k = 0; k < 8; k++) begin
                r[8*b+k] = w[8*b+7-k];
            end
        end
        return r;
    endfunction

    // Type-1 packet header for a single-word access; the 16-bit form sits in the low half.
    function automatic logic [31:0] hdr_word(input logic [1:0] op, input logic [5:0] addr);
        if (DATA_W == 32) return {3'b001, op, 8'h00, addr, 2'b00, 11'd1};
        else              return {16'h0000, 3'b001, op, addr, 5'd1};
    endfunction

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        errflag_d = errflag_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: if (REQ) begin
                state_d = S_DUMMY;
                rd_d    = REQ_RD;
                addr_d  = REQ_ADDR;
                wdata_d = REQ_WDATA;
            end
            S_DUMMY:   state_d = S_SYNC;
            S_SYNC:    if (DATA_W == 32 || cnt_q == 16'd1) state_d = S_HDR;
            S_HDR:     state_d = rd_q ? S_NOOP : S_WDATA;
            S_WDATA:   state_d = S_NOOP;
            S_NOOP:    if (cnt_q == NOOP_LAST) state_d = rd_q ? S_RD_TURN : S_DSH;
            S_RD_TURN: state_d = S_RD_CAP;
            S_RD_CAP: begin
                if (!ICAP_BUSY) begin
                    rdata_d = (BIT_SWAP != 0) ? byte_rev(ICAP_O) : ICAP_O;
                    state_d = S_RD_BACK;
                end else if (cnt_q == TO_LAST) begin
                    errflag_d = 1'b1;
                    state_d   = S_RD_BACK;
                end
            end
            S_RD_BACK: state_d = S_RD_REST;
            S_RD_REST: state_d = S_DSH;
            S_DSH:     state_d = S_DSD;
            S_DSD:     state_d = S_DONE;
            S_DONE: begin
                errflag_d = 1'b0;
                state_d   = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 16'd1;
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        ce_d   = 1'b1;
        wr_d   = 1'b0;
        word   = '0;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_DUMMY: begin
                ce_d = 1'b0;
                word = '1;
            end
            S_SYNC: begin
                ce_d = 1'b0;
                if (DATA_W == 32)          word = DATA_W'(32'hAA995566);
                else if (cnt_d == 16'd0)   word = DATA_W'(32'h0000AA99);
                else                       word = DATA_W'(32'h00005566);
            end
            S_HDR: begin
                ce_d = 1'b0;
                word = DATA_W'(hdr_word(rd_q ? 2'b01 : 2'b10, addr_q));
            end
            S_WDATA: begin
                ce_d = 1'b0;
                word = wdata_q;
            end
            S_NOOP: begin
                ce_d = 1'b0;
                word = (DATA_W == 32) ? DATA_W'(32'h20000000) : DATA_W'(32'h00002000);
            end
            S_RD_TURN: wr_d = 1'b1;
            S_RD_CAP: begin
                ce_d = 1'b0;
                wr_d = 1'b1;
            end
            S_RD_BACK: wr_d = 1'b1;
            S_DSH: begin
                ce_d = 1'b0;
                word = DATA_W'(hdr_word(2'b10, CMD_ADDR));
            end
            S_DSD: begin
                ce_d = 1'b0;
                word = DATA_W'(32'h0000000D);
            end
            S_DONE: begin
                ack_d = 1'b1;
                err_d = errflag_q;
            end
            default: ;
        endcase
        icap_i_d = (BIT_SWAP != 0) ? byte_rev(word) : word;
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            errflag_q <= 1'b0;
            rdata_q   <= '0;
            ce_q      <= 1'b1;
            wr_q      <= 1'b0;
            icap_i_q  <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            errflag_q <= errflag_d;
            rdata_q   <= rdata_d;
            ce_q      <= ce_d;
            wr_q      <= wr_d;
            icap_i_q  <= icap_i_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign ACK        = ack_q;
    assign ERR        = err_q;
    assign RDATA      = rdata_q;
    assign SEQ_BUSY   = busy_q;
    assign ICAP_CE    = ce_q;
    assign ICAP_WRITE = wr_q;
    assign ICAP_I     = icap_i_q;

endmodule

// File: tb/tb_icap_cmd_seq.sv
// Directed bench: a 16-bit unswapped instance and a 32-bit byte-swapped instance.
module tb_icap_cmd_seq;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        a_req, a_rd, a_ack, a_err, a_seq_busy, a_ce, a_wr, a_icap_busy;
    logic [5:0]  a_addr;
    logic [15:0] a_wdata, a_rdata, a_icap_i, a_icap_o;

    logic        b_req, b_rd, b_ack, b_err, b_seq_busy, b_ce, b_wr, b_icap_busy;
    logic [5:0]  b_addr;
    logic [31:0] b_wdata, b_rdata, b_icap_i, b_icap_o;

    icap_cmd_seq #(.DATA_W(16), .NOOP_CNT(2), .BIT_SWAP(0), .TIMEOUT(4)) dut16 (
        .CLK(clk), .RST_B(rst_b), .REQ(a_req), .REQ_RD(a_rd), .REQ_ADDR(a_addr),
        .REQ_WDATA(a_wdata), .ACK(a_ack), .ERR(a_err), .RDATA(a_rdata),
        .SEQ_BUSY(a_seq_busy), .ICAP_CE(a_ce), .ICAP_WRITE(a_wr), .ICAP_I(a_icap_i),
        .ICAP_O(a_icap_o), .ICAP_BUSY(a_icap_busy)
    );

    icap_cmd_seq #(.DATA_W(32), .BIT_SWAP(1)) dut32 (
        .CLK(clk), .RST_B(rst_b), .REQ(b_req), .REQ_RD(b_rd), .REQ_ADDR(b_addr),
        .REQ_WDATA(b_wdata), .ACK(b_ack), .ERR(b_err), .RDATA(b_rdata),
        .SEQ_BUSY(b_seq_busy), .ICAP_CE(b_ce), .ICAP_WRITE(b_wr), .ICAP_I(b_icap_i),
        .ICAP_O(b_icap_o), .ICAP_BUSY(b_icap_busy)
    );

    task automatic test_reset;
        rst_b = 1'b0;
        a_req = 0; a_rd = 0; a_addr = '0; a_wdata = '0; a_icap_o = '0; a_icap_busy = 1;
        b_req = 0; b_rd = 0; b_addr = '0; b_wdata = '0; b_icap_o = '0; b_icap_busy = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_ce, a_wr, a_ack, a_err, a_seq_busy} !== 5'b10000 || a_icap_i !== 16'h0 || a_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset16: ce/wr/ack/err/busy=%b i=%h rdata=%h, expected 10000 0000 0000",
                     {a_ce, a_wr, a_ack, a_err, a_seq_busy}, a_icap_i, a_rdata);
        end
        checks++;
        if ({b_ce, b_wr, b_ack, b_err, b_seq_busy} !== 5'b10000 || b_icap_i !== 32'h0 || b_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset32: ce/wr/ack/err/busy=%b i=%h rdata=%h, expected 10000 0 0",
                     {b_ce, b_wr, b_ack, b_err, b_seq_busy}, b_icap_i, b_rdata);
        end
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (a_seq_busy !== 1'b0 || a_ce !== 1'b1) begin
            errors++;
            $display("FAIL idle16: busy=%b ce=%b, expected busy=0 ce=1", a_seq_busy, a_ce);
        end
    endtask

    task automatic test_write16;
        logic [15:0] exp_w [9] = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h30A1, 16'h000E,
                                   16'h2000, 16'h2000, 16'h30A1, 16'h000D};
        a_req = 1; a_rd = 0; a_addr = 6'h05; a_wdata = 16'h000E;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) a_req = 0;
            checks++;
            if (a_ce !== 1'b0 || a_wr !== 1'b0 || a_icap_i !== exp_w[i]) begin
                errors++;
                $display("FAIL wr16_word%0d: ce=%b wr=%b i=%h, expected ce=0 wr=0 i=%h",
                         i, a_ce, a_wr, a_icap_i, exp_w[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b1 || a_err !== 1'b0 || a_ce !== 1'b1 || a_icap_i !== 16'h0) begin
            errors++;
            $display("FAIL wr16_done: ack=%b err=%b ce=%b i=%h, expected ack=1 err=0 ce=1 i=0000",
                     a_ack, a_err, a_ce, a_icap_i);
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b0 || a_seq_busy !== 1'b0) begin
            errors++;
            $display("FAIL wr16_after: ack=%b busy=%b, expected 0 0", a_ack, a_seq_busy);
        end
    endtask

    task automatic test_read16;
        logic [17:0] exp_r [15] = '{18'h0FFFF, 18'h0AA99, 18'h05566, 18'h02921, 18'h02000,
                                    18'h02000, 18'h30000, 18'h10000, 18'h10000, 18'h10000,
                                    18'h10000, 18'h30000, 18'h20000, 18'h030A1, 18'h0000D};
        a_req = 1; a_rd = 1; a_addr = 6'h09; a_icap_busy = 1; a_icap_o = 16'h0000;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 0) a_req = 0;
            checks++;
            if ({a_ce, a_wr, a_icap_i} !== exp_r[i]) begin
                errors++;
                $display("FAIL rd16_cyc%0d: ce/wr/i=%h, expected %h", i, {a_ce, a_wr, a_icap_i}, exp_r[i]);
            end
            a_icap_busy = (i == 10) ? 1'b0 : 1'b1;
            a_icap_o    = (i == 10) ? 16'h1234 : 16'h0000;
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b1 || a_err !== 1'b0 || a_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL rd16_done: ack=%b err=%b rdata=%h, expected 1 0 1234", a_ack, a_err, a_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_read_timeout;
        logic [17:0] exp_r [15] = '{18'h0FFFF, 18'h0AA99, 18'h05566, 18'h02921, 18'h02000,
                                    18'h02000, 18'h30000, 18'h10000, 18'h10000, 18'h10000,
                                    18'h10000, 18'h30000, 18'h20000, 18'h030A1, 18'h0000D};
        a_req = 1; a_rd = 1; a_addr = 6'h09; a_icap_busy = 1; a_icap_o = 16'hBEEF;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 0) a_req = 0;
            checks++;
            if ({a_ce, a_wr, a_icap_i} !== exp_r[i]) begin
                errors++;
                $display("FAIL rdto_cyc%0d: ce/wr/i=%h, expected %h", i, {a_ce, a_wr, a_icap_i}, exp_r[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b1 || a_err !== 1'b1 || a_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL rdto_done: ack=%b err=%b rdata=%h, expected 1 1 1234", a_ack, a_err, a_rdata);
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL rdto_clear: ack=%b err=%b, expected 0 0", a_ack, a_err);
        end
    endtask

    task automatic test_reset_mid_noop;
        logic [15:0] exp_w [9] = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h30A1, 16'h000E,
                                   16'h2000, 16'h2000, 16'h30A1, 16'h000D};
        a_req = 1; a_rd = 0; a_addr = 6'h05; a_wdata = 16'h000E;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) a_req = 0;
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if (a_ce !== 1'b1 || a_wr !== 1'b0 || a_icap_i !== 16'h0 || a_seq_busy !== 1'b0 || a_rdata !== 16'h0) begin
            errors++;
            $display("FAIL rst_async: ce=%b wr=%b i=%h busy=%b rdata=%h, expected 1 0 0000 0 0000",
                     a_ce, a_wr, a_icap_i, a_seq_busy, a_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_ack !== 1'b0 || a_ce !== 1'b1) begin
                errors++;
                $display("FAIL rst_hold%0d: ack=%b ce=%b, expected 0 1", i, a_ack, a_ce);
            end
        end
        rst_b = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b0 || a_seq_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_noack: ack=%b busy=%b, expected 0 0", a_ack, a_seq_busy);
        end
        a_req = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) a_req = 0;
            checks++;
            if (a_ce !== 1'b0 || a_icap_i !== exp_w[i]) begin
                errors++;
                $display("FAIL rst_rerun%0d: ce=%b i=%h, expected ce=0 i=%h", i, a_ce, a_icap_i, exp_w[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b1 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_rerun_done: ack=%b err=%b, expected 1 0", a_ack, a_err);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp1 [9] = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h30A1, 16'h000E,
                                  16'h2000, 16'h2000, 16'h30A1, 16'h000D};
        logic [15:0] exp2 [8] = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0055,
                                  16'h2000, 16'h2000, 16'h30A1, 16'h000D};
        a_req = 1; a_rd = 0; a_addr = 6'h05; a_wdata = 16'h000E;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) a_wdata = 16'h0055;
            checks++;
            if (a_ce !== 1'b0 || a_icap_i !== exp1[i]) begin
                errors++;
                $display("FAIL b2b_first%0d: ce=%b i=%h, expected ce=0 i=%h", i, a_ce, a_icap_i, exp1[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ack1: ack=%b, expected 1", a_ack);
        end
        @(negedge clk);
        checks++;
        if (a_seq_busy !== 1'b0 || a_ce !== 1'b1 || a_ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b ce=%b ack=%b, expected 0 1 0", a_seq_busy, a_ce, a_ack);
        end
        @(negedge clk);
        a_req = 0;
        checks++;
        if (a_seq_busy !== 1'b1 || a_ce !== 1'b0 || a_icap_i !== 16'hFFFF) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b ce=%b i=%h, expected 1 0 ffff", a_seq_busy, a_ce, a_icap_i);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (a_ce !== 1'b0 || a_icap_i !== exp2[i]) begin
                errors++;
                $display("FAIL b2b_second%0d: ce=%b i=%h, expected ce=0 i=%h", i, a_ce, a_icap_i, exp2[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b1 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack2: ack=%b err=%b, expected 1 0", a_ack, a_err);
        end
        @(negedge clk);
        checks++;
        if (a_seq_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: busy=%b, expected 0", a_seq_busy);
        end
    endtask

    task automatic test_write32_swap;
        logic [31:0] exp_w [8] = '{32'hFFFFFFFF, 32'h5599AA66, 32'h0C000580, 32'h00000070,
                                   32'h04000000, 32'h04000000, 32'h0C000580, 32'h000000B0};
        b_req = 1; b_rd = 0; b_addr = 6'h05; b_wdata = 32'h0000000E;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) b_req = 0;
            checks++;
            if (b_ce !== 1'b0 || b_wr !== 1'b0 || b_icap_i !== exp_w[i]) begin
                errors++;
                $display("FAIL wr32_word%0d: ce=%b wr=%b i=%h, expected ce=0 wr=0 i=%h",
                         i, b_ce, b_wr, b_icap_i, exp_w[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (b_ack !== 1'b1 || b_err !== 1'b0 || b_ce !== 1'b1) begin
            errors++;
            $display("FAIL wr32_done: ack=%b err=%b ce=%b, expected 1 0 1", b_ack, b_err, b_ce);
        end
        @(negedge clk);
    endtask

    task automatic test_read32_swap;
        logic [33:0] exp_r [11] = '{{2'b00, 32'hFFFFFFFF}, {2'b00, 32'h5599AA66}, {2'b00, 32'h14800480},
                                    {2'b00, 32'h04000000}, {2'b00, 32'h04000000}, {2'b11, 32'h0},
                                    {2'b01, 32'h0}, {2'b11, 32'h0}, {2'b10, 32'h0},
                                    {2'b00, 32'h0C000580}, {2'b00, 32'h000000B0}};
        b_req = 1; b_rd = 1; b_addr = 6'h09; b_icap_busy = 1; b_icap_o = 32'h0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 0) b_req = 0;
            checks++;
            if ({b_ce, b_wr, b_icap_i} !== exp_r[i]) begin
                errors++;
                $display("FAIL rd32_cyc%0d: ce/wr/i=%h, expected %h", i, {b_ce, b_wr, b_icap_i}, exp_r[i]);
            end
            b_icap_busy = (i == 6) ? 1'b0 : 1'b1;
            b_icap_o    = (i == 6) ? 32'h01028040 : 32'h0;
        end
        @(negedge clk);
        checks++;
        if (b_ack !== 1'b1 || b_err !== 1'b0 || b_rdata !== 32'h80400102) begin
            errors++;
            $display("FAIL rd32_done: ack=%b err=%b rdata=%h, expected 1 0 80400102", b_ack, b_err, b_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write16();
        test_read16();
        test_read_timeout();
        test_reset_mid_noop();
        test_back_to_back();
        test_write32_swap();
        test_read32_swap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
